saes_decrypt: RTL and testbench

Iterative Simplified-AES (S-AES) decryption core: the inverse direction of our existing S-AES encrypt datapath and its forward nibble S-box. It takes a 16-bit ciphertext and a 16-bit key, expands round keys on-chip, and applies inverse rounds over several clock cycles. It uses a start/done handshake and is built around an internal 4-bit inverse S-box.

---
 rtl/saes_decrypt.sv | 173 +++++++++++++++++
 tb/tb_saes_decrypt.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/saes_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : saes_decrypt
// Description : Iterative Simplified-AES decryption core. Latches a 16-bit
//               ciphertext and key on start, expands the round keys over two
//               cycles, then applies the inverse rounds over three cycles.
//               Start/done handshake, fully registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module saes_decrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ct_in,
  input  logic [15:0] key_in,
  output logic [15:0] pt_out,
  output logic        done,
  output logic        busy
);

  // Round constants for the two key-expansion steps
  localparam logic [7:0] C_RCON1 = 8'h80;
  localparam logic [7:0] C_RCON2 = 8'h30;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KEY1 = 3'd1,
    KEY2 = 3'd2,
    RND0 = 3'd3,
    RND1 = 3'd4,
    RND2 = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_ct;   // latched ciphertext
  logic [15:0] r_k0;   // latched key = K0 (w0w1)
  logic [15:0] r_k1;   // w2w3
  logic [15:0] r_k2;   // w4w5
  logic [15:0] r_st;   // round state

  logic [7:0]  w_w2, w_w3, w_w4, w_w5;
  logic [15:0] w_rnd1;
  logic [15:0] w_rnd2;

  // --------------------------------------------------------------------------
  // Nibble primitives
  // --------------------------------------------------------------------------
  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
      4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
      4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
      4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
      4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^4), reducing with x^4+x+1
  function automatic logic [3:0] gf_mul2(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  // 9 = x^3 + 1
  function automatic logic [3:0] gf_mul9(input logic [3:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ x;
  endfunction

  // Key-expansion g(): RotNib, forward SubNib, then round constant
  function automatic logic [7:0] key_g(input logic [7:0] w, input logic [7:0] rcon);
    return rcon ^ {sbox(w[3:0]), sbox(w[7:4])};
  endfunction

  function automatic logic [15:0] inv_shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] inv_sub_nib(input logic [15:0] s);
    return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
  endfunction

  function automatic logic [15:0] inv_mix_columns(input logic [15:0] s);
    logic [3:0] a0, b0, a1, b1;
    a0 = s[15:12];
    b0 = s[11:8];
    a1 = s[7:4];
    b1 = s[3:0];
    return {gf_mul9(a0) ^ gf_mul2(b0), gf_mul2(a0) ^ gf_mul9(b0),
            gf_mul9(a1) ^ gf_mul2(b1), gf_mul2(a1) ^ gf_mul9(b1)};
  endfunction

  // --------------------------------------------------------------------------
  // Combinational round logic, consumed only by registers
  // --------------------------------------------------------------------------
  assign w_w2   = r_k0[15:8] ^ key_g(r_k0[7:0], C_RCON1);
  assign w_w3   = w_w2 ^ r_k0[7:0];
  assign w_w4   = r_k1[15:8] ^ key_g(r_k1[7:0], C_RCON2);
  assign w_w5   = w_w4 ^ r_k1[7:0];
  assign w_rnd1 = inv_mix_columns(inv_sub_nib(inv_shift_rows(r_st)) ^ r_k1);
  assign w_rnd2 = inv_sub_nib(inv_shift_rows(r_st)) ^ r_k0;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state sequencing: one fixed pass through the key and round steps
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = KEY1;
      KEY1:    w_next = KEY2;
      KEY2:    w_next = RND0;
      RND0:    w_next = RND1;
      RND1:    w_next = RND2;
      RND2:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and handshake registers, advanced by the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ct   <= 16'h0000;
      r_k0   <= 16'h0000;
      r_k1   <= 16'h0000;
      r_k2   <= 16'h0000;
      r_st   <= 16'h0000;
      pt_out <= 16'h0000;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ct <= ct_in;
            r_k0 <= key_in;
            busy <= 1'b1;
          end
        end
        KEY1: r_k1 <= {w_w2, w_w3};
        KEY2: r_k2 <= {w_w4, w_w5};
        RND0: r_st <= r_ct ^ r_k2;
        RND1: r_st <= w_rnd1;
        RND2: begin
          pt_out <= w_rnd2;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_saes_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_saes_decrypt
// Description : Directed and round-trip bench for saes_decrypt. Ciphertexts
//               for the sweep come from an S-AES encryption model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_saes_decrypt;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] ct_in;
  logic [15:0] key_in;
  logic [15:0] pt_out;
  logic        done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  saes_decrypt dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ct_in  (ct_in),
    .key_in (key_in),
    .pt_out (pt_out),
    .done   (done),
    .busy   (busy)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- encryption model (forward direction) ----------------
  function automatic logic [3:0] m_sbox(input logic [3:0] n);
    logic [63:0] tbl;
    tbl = 64'h94ABD1856203CEF7;
    return tbl[60 - 4*n +: 4];
  endfunction

  function automatic logic [3:0] m_gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [15:0] m_sub(input logic [15:0] s);
    return {m_sbox(s[15:12]), m_sbox(s[11:8]), m_sbox(s[7:4]), m_sbox(s[3:0])};
  endfunction

  function automatic logic [15:0] m_encrypt(input logic [15:0] pt, input logic [15:0] key);
    logic [7:0]  w0, w1, w2, w3, w4, w5;
    logic [15:0] s;
    w0 = key[15:8];
    w1 = key[7:0];
    w2 = w0 ^ 8'h80 ^ {m_sbox(w1[3:0]), m_sbox(w1[7:4])};
    w3 = w2 ^ w1;
    w4 = w2 ^ 8'h30 ^ {m_sbox(w3[3:0]), m_sbox(w3[7:4])};
    w5 = w4 ^ w3;
    s = pt ^ {w0, w1};
    s = m_sub(s);
    s = {s[15:12], s[3:0], s[7:4], s[11:8]};
    s = {s[15:12] ^ m_gmul(4'h4, s[11:8]), m_gmul(4'h4, s[15:12]) ^ s[11:8],
         s[7:4] ^ m_gmul(4'h4, s[3:0]),    m_gmul(4'h4, s[7:4]) ^ s[3:0]};
    s = s ^ {w2, w3};
    s = m_sub(s);
    s = {s[15:12], s[3:0], s[7:4], s[11:8]};
    return s ^ {w4, w5};
  endfunction

  // Issue start at the current (clock-low) time and wait for done.
  // lat = edges after the accepting edge (-1 on timeout); bcnt = sampled
  // cycles with busy high before done. glitch_at re-raises start with junk data.
  task automatic run_op(input logic [15:0] k, input logic [15:0] c, input bit hold,
                        input int glitch_at, output int lat, output int bcnt);
    key_in = k;
    ct_in  = c;
    start  = 1'b1;
    lat    = -1;
    bcnt   = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i - 1;
        break;
      end
      if (busy) bcnt++;
      if (i == glitch_at) begin
        start  = 1'b1;
        ct_in  = 16'hFFFF;
        key_in = 16'h0000;
      end else if (!hold) begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int lat, bcnt, extra;
    logic [15:0] k, p, c;

    rst = 1'b1; start = 1'b0; ct_in = 16'h0; key_in = 16'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_pt", pt_out, 16'h0000);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);

    // Known answer 1
    run_op(16'hA73B, 16'h0738, 1'b0, 0, lat, bcnt);
    check_eq("ka1_lat", lat, 5);
    check_eq("ka1_pt", pt_out, 16'h6F6B);
    check_eq("ka1_busy_cycles", bcnt, 5);
    check_eq("ka1_busy_at_done", busy, 1'b0);
    @(negedge clk);
    check_eq("ka1_done_pulse", done, 1'b0);
    check_eq("ka1_pt_hold", pt_out, 16'h6F6B);

    // Known answer 2
    run_op(16'h4AF5, 16'h24EC, 1'b0, 0, lat, bcnt);
    check_eq("ka2_lat", lat, 5);
    check_eq("ka2_pt", pt_out, 16'hD728);

    // Back-to-back: start held, vector 2 applied in vector 1's done cycle
    run_op(16'hA73B, 16'h0738, 1'b1, 0, lat, bcnt);
    check_eq("b2b1_lat", lat, 5);
    check_eq("b2b1_pt", pt_out, 16'h6F6B);
    run_op(16'h4AF5, 16'h24EC, 1'b0, 0, lat, bcnt);
    check_eq("b2b2_lat", lat, 5);
    check_eq("b2b2_pt", pt_out, 16'hD728);
    @(negedge clk);

    // Busy protection: start pulse with junk data at E2
    run_op(16'hA73B, 16'h0738, 1'b0, 2, lat, bcnt);
    check_eq("busy_prot_lat", lat, 5);
    check_eq("busy_prot_pt", pt_out, 16'h6F6B);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq("busy_prot_one_done", extra, 0);

    // Reset mid-operation, between E3 and E4
    key_in = 16'hA73B; ct_in = 16'h0738; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_pt", pt_out, 16'h0000);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq("midrst_no_done", extra, 0);
    check_eq("midrst_pt_hold", pt_out, 16'h0000);
    run_op(16'hA73B, 16'h0738, 1'b0, 0, lat, bcnt);
    check_eq("restart_lat", lat, 5);
    check_eq("restart_pt", pt_out, 16'h6F6B);

    // Round-trip sweep
    for (int n = 0; n < 2000; n++) begin
      k = 16'($urandom);
      p = 16'($urandom);
      c = m_encrypt(p, k);
      run_op(k, c, 1'b0, 0, lat, bcnt);
      if (lat != 5) check_eq("sweep_lat", lat, 5);
      check_eq("sweep_pt", pt_out, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
